// File: rtl/chaos_pkg.sv
// Shared types and constants for the chaos key quantizer: FSM states,
// IEEE-754 double field positions and the mantissa-fold key function.
package chaos_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DISCARD,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_e;

  localparam int EXP_MSB = 62;
  localparam int EXP_LSB = 52;
  localparam logic [15:0] NAN_KEY = 16'h0000;

  function automatic logic is_nonfinite(input logic [10:0] exp_f);
    return &exp_f;
  endfunction

  // Fold mantissa bits [47:32] onto [15:0]; Inf/NaN collapse to a fixed key.
  function automatic logic [15:0] fold_key(input logic [10:0] exp_f,
                                           input logic [15:0] mant_hi,
                                           input logic [15:0] mant_lo);
    return is_nonfinite(exp_f) ? NAN_KEY : (mant_hi ^ mant_lo);
  endfunction

endpackage

// File: rtl/chaos_key_fifo.sv
// Synchronous FIFO buffering quantized key words ahead of the block-RAM writer.
module chaos_key_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; consumers gate rdata with !empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/chaos_key_quantizer.sv
// Turns a stream of attractor samples (three doubles) into 16-bit keys with RAM addresses.
// Optional build macro CHAOS_KEY_STATS_EN adds a saturating Inf/NaN component counter.
module chaos_key_quantizer
  import chaos_pkg::*;
#(
  parameter int DISCARD    = 1024,
  parameter int SAMPLES    = 65536,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_x,
  input  logic [63:0] in_y,
  input  logic [63:0] in_z,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [15:0] key_x,
  output logic [15:0] key_y,
  output logic [15:0] key_z,
  output logic [15:0] key_addr,
  output logic        done
`ifdef CHAOS_KEY_STATS_EN
  ,
  output logic [15:0] nonfinite_cnt
`endif
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] DISC_LAST = 32'(DISCARD - 1);
  localparam logic [16:0] SAMP_LAST = 17'(SAMPLES - 1);

  state_e      state_q, state_d;
  logic [31:0] disc_cnt_q, disc_cnt_d;
  logic [16:0] samp_cnt_q, samp_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        stage_v_q, stage_v_d;
  logic [63:0] stage_q, stage_d;

  logic          start_ok, room, run_accept, disc_accept;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt;
  logic [63:0]   head;
  logic [15:0]   qx, qy, qz;
  logic          unused_bits;

  assign qx = fold_key(in_x[EXP_MSB:EXP_LSB], in_x[47:32], in_x[15:0]);
  assign qy = fold_key(in_y[EXP_MSB:EXP_LSB], in_y[47:32], in_y[15:0]);
  assign qz = fold_key(in_z[EXP_MSB:EXP_LSB], in_z[47:32], in_z[15:0]);
  assign unused_bits = ^{in_x[63], in_x[51:48], in_x[31:16],
                         in_y[63], in_y[51:48], in_y[31:16],
                         in_z[63], in_z[51:48], in_z[31:16]};

  // The staged key counts against FIFO space, so a push can never land on a full FIFO.
  assign room        = !fifo_full && ((32'(fifo_cnt) + 32'(stage_v_q)) < 32'(FIFO_DEPTH));
  assign start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign disc_accept = (state_q == ST_DISCARD) && in_valid;
  assign run_accept  = (state_q == ST_RUN) && in_valid && room;
  assign in_ready    = (state_q == ST_DISCARD) || ((state_q == ST_RUN) && room);
  assign done        = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    disc_cnt_d = disc_cnt_q;
    samp_cnt_d = samp_cnt_q;
    addr_d     = addr_q;
    stage_v_d  = run_accept;
    stage_d    = stage_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d    = (DISCARD == 0) ? ST_RUN : ST_DISCARD;
          disc_cnt_d = '0;
          samp_cnt_d = '0;
          addr_d     = '0;
        end
      end
      ST_DISCARD: begin
        if (disc_accept) begin
          disc_cnt_d = disc_cnt_q + 32'd1;
          if (disc_cnt_q == DISC_LAST) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_accept) begin
          stage_d    = {qx, qy, qz, addr_q};
          addr_d     = addr_q + 16'd1;
          samp_cnt_d = samp_cnt_q + 17'd1;
          if (samp_cnt_q == SAMP_LAST) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (!stage_v_q && fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      disc_cnt_q <= '0;
      samp_cnt_q <= '0;
      addr_q     <= '0;
      stage_v_q  <= 1'b0;
      stage_q    <= '0;
    end else begin
      state_q    <= state_d;
      disc_cnt_q <= disc_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      addr_q     <= addr_d;
      stage_v_q  <= stage_v_d;
      stage_q    <= stage_d;
    end
  end

  chaos_key_fifo #(
    .WIDTH(64),
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (stage_v_q),
    .wdata(stage_q),
    .pop  (key_valid && key_ready),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );

  assign key_valid = !fifo_empty;
  assign key_x     = key_valid ? head[63:48] : '0;
  assign key_y     = key_valid ? head[47:32] : '0;
  assign key_z     = key_valid ? head[31:16] : '0;
  assign key_addr  = key_valid ? head[15:0]  : '0;

`ifdef CHAOS_KEY_STATS_EN
  logic [15:0] nf_cnt_q, nf_cnt_d;
  logic [1:0]  nf_inc;
  logic [16:0] nf_sum;

  always_comb begin
    nf_inc   = 2'(is_nonfinite(in_x[EXP_MSB:EXP_LSB])) +
               2'(is_nonfinite(in_y[EXP_MSB:EXP_LSB])) +
               2'(is_nonfinite(in_z[EXP_MSB:EXP_LSB]));
    nf_sum   = {1'b0, nf_cnt_q} + 17'(nf_inc);
    nf_cnt_d = nf_cnt_q;
    if (start_ok)        nf_cnt_d = '0;
    else if (run_accept) nf_cnt_d = nf_sum[16] ? 16'hFFFF : nf_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) nf_cnt_q <= '0;
    else        nf_cnt_q <= nf_cnt_d;
  end

  assign nonfinite_cnt = nf_cnt_q;
`endif

endmodule

// File: tb/tb_chaos_key_quantizer.sv
// Randomized bench for chaos_key_quantizer: a short-run instance and a longer-run instance,
// both checked against a transaction-level model of discard/quantize/address rules.
module tb_chaos_key_quantizer;

  localparam int DISC = 2;
  localparam int FD   = 4;

  logic        clk;
  logic        reset     [2];
  logic        start     [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [63:0] in_x      [2];
  logic [63:0] in_y      [2];
  logic [63:0] in_z      [2];
  logic        key_valid [2];
  logic        key_ready [2];
  logic [15:0] key_x     [2];
  logic [15:0] key_y     [2];
  logic [15:0] key_z     [2];
  logic [15:0] key_addr  [2];
  logic        done      [2];
`ifdef CHAOS_KEY_STATS_EN
  logic [15:0] nonfinite_cnt [2];
`endif

  int checks   = 0;
  int failures = 0;

  // Model state: keys expected in order, keys observed at the output, accept bookkeeping.
  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int disc_seen, addr_n, nf_exp, cyc, first_acc, first_kv;

  chaos_key_quantizer #(.DISCARD(DISC), .SAMPLES(3), .FIFO_DEPTH(FD)) dut_a (
    .clk(clk), .reset(reset[0]), .start(start[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_x(in_x[0]), .in_y(in_y[0]), .in_z(in_z[0]),
    .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key_x(key_x[0]),
    .key_y(key_y[0]), .key_z(key_z[0]), .key_addr(key_addr[0]), .done(done[0])
`ifdef CHAOS_KEY_STATS_EN
    , .nonfinite_cnt(nonfinite_cnt[0])
`endif
  );

  chaos_key_quantizer #(.DISCARD(DISC), .SAMPLES(16), .FIFO_DEPTH(FD)) dut_b (
    .clk(clk), .reset(reset[1]), .start(start[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_x(in_x[1]), .in_y(in_y[1]), .in_z(in_z[1]),
    .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key_x(key_x[1]),
    .key_y(key_y[1]), .key_z(key_z[1]), .key_addr(key_addr[1]), .done(done[1])
`ifdef CHAOS_KEY_STATS_EN
    , .nonfinite_cnt(nonfinite_cnt[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int samp_of(input int u);
    return (u == 0) ? 3 : 16;
  endfunction

  function automatic int nonfin(input logic [63:0] d);
    longint unsigned v;
    v = d;
    return (((v >> 52) & 64'h7FF) == 64'h7FF) ? 1 : 0;
  endfunction

  function automatic logic [15:0] ref_key(input logic [63:0] d);
    longint unsigned v;
    v = d;
    if (nonfin(d) != 0) return 16'h0000;
    return 16'(((v >> 32) ^ v) & 64'hFFFF);
  endfunction

  function automatic logic [63:0] rand_d();
    logic [63:0] d;
    d = {$urandom, $urandom};
    if ($urandom_range(7) == 0) d[62:52] = '1;
    return d;
  endfunction

  task automatic model_start();
    exp_q.delete();
    obs_q.delete();
    disc_seen = 0;
    addr_n    = 0;
    nf_exp    = 0;
    first_acc = -1;
    first_kv  = -1;
  endtask

  // One clock: observe handshakes at the falling edge, then move to just after the rising edge.
  task automatic step(input int u);
    @(negedge clk);
    cyc++;
    if (in_valid[u] && in_ready[u]) begin
      if (disc_seen < DISC) disc_seen++;
      else begin
        exp_q.push_back({ref_key(in_x[u]), ref_key(in_y[u]), ref_key(in_z[u]), 16'(addr_n)});
        nf_exp += nonfin(in_x[u]) + nonfin(in_y[u]) + nonfin(in_z[u]);
        if (first_acc < 0) first_acc = cyc;
        addr_n++;
      end
    end
    if (key_valid[u] && first_kv < 0) first_kv = cyc;
    if (key_valid[u] && key_ready[u])
      obs_q.push_back({key_x[u], key_y[u], key_z[u], key_addr[u]});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input int u);
    start[u]    = 1'b1;
    in_valid[u] = 1'b0;
    model_start();
    step(u);
    start[u] = 1'b0;
  endtask

  task automatic feed(input int u, input int rdy_pct, input bit nan_y, output bit ok);
    int budget;
    budget = 2000;
    while (addr_n < samp_of(u) && budget > 0) begin
      in_valid[u]  = ($urandom_range(99) < 80);
      in_x[u]      = rand_d();
      in_y[u]      = nan_y ? 64'h7FF8000000000000 : rand_d();
      in_z[u]      = rand_d();
      key_ready[u] = ($urandom_range(99) < rdy_pct);
      step(u);
      budget--;
    end
    in_valid[u]  = 1'b0;
    key_ready[u] = 1'b1;
    while (!done[u] && budget > 0) begin
      step(u);
      budget--;
    end
    ok = done[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b0;
      start[u] = 1'b0;
      in_valid[u] = 1'b0;
      key_ready[u] = 1'b1;
      in_x[u] = '0; in_y[u] = '0; in_z[u] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (in_ready[u] !== 1'b0) begin failures++; $display("FAIL reset_in_ready[%0d]: got %b want 0", u, in_ready[u]); end
      checks++;
      if (key_valid[u] !== 1'b0) begin failures++; $display("FAIL reset_key_valid[%0d]: got %b want 0", u, key_valid[u]); end
      checks++;
      if (done[u] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d]: got %b want 0", u, done[u]); end
      checks++;
      if ({key_x[u], key_y[u], key_z[u], key_addr[u]} !== 64'h0) begin
        failures++;
        $display("FAIL reset_keys[%0d]: got %h want 0", u, {key_x[u], key_y[u], key_z[u], key_addr[u]});
      end
    end
    reset[0] = 1'b1;
    reset[1] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_spec_vector();
    int budget;
    drive_start(0);
    checks++;
    if (done[0] !== 1'b0) begin failures++; $display("FAIL spec_done_early: got %b want 0", done[0]); end
    budget = 50;
    key_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_x[0]      = 64'h4019058A7000CFFC;
    while (disc_seen + addr_n < 5 && budget > 0) begin
      in_y[0] = rand_d();
      in_z[0] = rand_d();
      step(0);
      budget--;
    end
    in_valid[0] = 1'b0;
    while (!done[0] && budget > 0) begin step(0); budget--; end
    checks++;
    if (done[0] !== 1'b1) begin failures++; $display("FAIL spec_done: got %b want 1", done[0]); end
    checks++;
    if (in_ready[0] !== 1'b0) begin failures++; $display("FAIL spec_in_ready_after: got %b want 0", in_ready[0]); end
    checks++;
    if (first_kv - first_acc !== 2) begin
      failures++;
      $display("FAIL spec_latency: got %0d cycles want 2", first_kv - first_acc);
    end
    checks++;
    if (obs_q.size() != 3) begin
      failures++;
      $display("FAIL spec_key_count: got %0d want 3", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0][63:48] !== 16'hCA76) begin failures++; $display("FAIL spec_key_x: got %h want CA76", obs_q[0][63:48]); end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL spec_key[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
        checks++;
        if (obs_q[i][15:0] !== 16'(i)) begin failures++; $display("FAIL spec_addr[%0d]: got %0d want %0d", i, obs_q[i][15:0], i); end
      end
    end
  endtask

  task automatic test_nan_restart();
    bit ok;
    checks++;
    if (done[0] !== 1'b1) begin failures++; $display("FAIL restart_done_before: got %b want 1", done[0]); end
    drive_start(0);
    checks++;
    if (done[0] !== 1'b0) begin failures++; $display("FAIL restart_done_clear: got %b want 0", done[0]); end
    feed(0, 100, 1'b1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL nan_timeout: got done=0 want done=1"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL nan_key_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL nan_key[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
      checks++;
      if (obs_q[0][47:32] !== 16'h0000) begin failures++; $display("FAIL nan_key_y: got %h want 0000", obs_q[0][47:32]); end
    end
`ifdef CHAOS_KEY_STATS_EN
    checks++;
    if (nonfinite_cnt[0] !== 16'((nf_exp > 65535) ? 65535 : nf_exp)) begin
      failures++;
      $display("FAIL nan_stats: got %0d want %0d", nonfinite_cnt[0], nf_exp);
    end
`endif
  endtask

  task automatic test_backpressure();
    bit ok, have;
    logic [15:0] held;
    have = 1'b0;
    held = '0;
    drive_start(1);
    key_ready[1] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid[1] = 1'b1;
      in_x[1] = rand_d(); in_y[1] = rand_d(); in_z[1] = rand_d();
      step(1);
      if (key_valid[1]) begin
        if (!have) begin held = key_x[1]; have = 1'b1; end
        else begin
          checks++;
          if (key_x[1] !== held) begin failures++; $display("FAIL bp_stable c%0d: got %h want %h", c, key_x[1], held); end
        end
      end
    end
    checks++;
    if (in_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready[1]); end
    checks++;
    if (key_valid[1] !== 1'b1) begin failures++; $display("FAIL bp_key_valid: got %b want 1", key_valid[1]); end
    checks++;
    if (exp_q.size() != FD) begin failures++; $display("FAIL bp_accepted: got %0d want %0d", exp_q.size(), FD); end
    feed(1, 60, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_timeout: got done=0 want done=1"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_key_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_key[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, hit;
    int budget;
    hit = 1'b0;
    budget = 200;
    drive_start(1);
    key_ready[1] = 1'b1;
    while (!hit && budget > 0) begin
      in_valid[1] = ($urandom_range(99) < 80);
      in_x[1] = rand_d(); in_y[1] = rand_d(); in_z[1] = rand_d();
      step(1);
      hit = key_valid[1] && (key_addr[1] == 16'd5);
      budget--;
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL mid_reach_addr5: got no addr 5 want addr 5 at head"); end
    reset[1] = 1'b0;
    #1;
    checks++;
    if ({in_ready[1], key_valid[1], done[1]} !== 3'b000) begin
      failures++;
      $display("FAIL mid_reset_ctrl: got %b want 000", {in_ready[1], key_valid[1], done[1]});
    end
    checks++;
    if ({key_x[1], key_y[1], key_z[1], key_addr[1]} !== 64'h0) begin
      failures++;
      $display("FAIL mid_reset_keys: got %h want 0", {key_x[1], key_y[1], key_z[1], key_addr[1]});
    end
    @(posedge clk);
    #1;
    reset[1] = 1'b1;
    in_valid[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1);
      checks++;
      if ({in_ready[1], key_valid[1]} !== 2'b00) begin
        failures++;
        $display("FAIL mid_post_reset c%0d: got %b want 00", c, {in_ready[1], key_valid[1]});
      end
    end
    drive_start(1);
    feed(1, 80, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_restart_timeout: got done=0 want done=1"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL mid_key_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      checks++;
      if (obs_q[0][15:0] !== 16'd0) begin failures++; $display("FAIL mid_first_addr: got %0d want 0", obs_q[0][15:0]); end
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_key[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    drive_start(1);
    key_ready[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid[1] = ($urandom_range(99) < 80);
      in_x[1] = rand_d(); in_y[1] = rand_d(); in_z[1] = rand_d();
      start[1] = (c == 8);
      step(1);
    end
    start[1] = 1'b0;
    feed(1, 80, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ign_timeout: got done=0 want done=1"); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ign_key_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ign_key[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    cyc = 0;
    model_start();
    test_reset();
    test_spec_vector();
    test_nan_restart();
    test_backpressure();
    test_reset_mid_run();
    test_start_ignored();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chaos_key_quantizer.md
CHAOS_KEY_QUANTIZER -- requirements
Module: chaos_key_quantizer

Interface
REQ-001 SHALL have parameter DISCARD, default 1024, meaning leading attractor samples dropped as transient.
REQ-002 SHALL have parameter SAMPLES, default 65536, meaning keys emitted per run (1..65536).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle run request.
REQ-007 SHALL have port in_valid  input  1  attractor sample {in_x,in_y,in_z} present.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid&&in_ready.
REQ-009 SHALL have port in_x, in_y, in_z  input  64 each  IEEE-754 doubles.
REQ-010 SHALL have port key_valid  output  1  FIFO head valid.
REQ-011 SHALL have port key_ready  input  1  downstream (block-RAM writer) accepts head.
REQ-012 SHALL have port key_x, key_y, key_z  output  16 each  quantized keys.
REQ-013 SHALL have port key_addr  output  16  RAM address of head key (0..SAMPLES-1).
REQ-014 SHALL have port done  output  1  run complete, all keys drained.

Function
REQ-015 SHALL implement FSM IDLE -> (start) DISCARD -> (DISCARD samples accepted) RUN -> (SAMPLES keys pushed) FLUSH -> (FIFO empty) DONE -> (start) DISCARD.
REQ-016 SHALL go DISCARD->RUN directly when DISCARD=0; start SHALL be ignored outside IDLE/DONE.
REQ-017 SHALL assert in_ready in DISCARD always, in RUN only when FIFO not full, otherwise deassert.
REQ-018 SHALL quantize each double d as key = d[47:32] ^ d[15:0] (mantissa fold), sign and exponent ignored.
REQ-019 SHALL substitute key 16'h0000 when exponent d[62:52] is all ones (Inf/NaN).
REQ-020 SHALL register the quantized triple plus address one cycle after acceptance, then push into FIFO (latency: accept to key_valid = 2 cycles when FIFO empty).
REQ-021 SHALL pop FIFO on key_valid&&key_ready; simultaneous push and pop on a full FIFO SHALL NOT be permitted (in_ready already low when full, counting in-flight stage).
REQ-022 SHALL increment key_addr sequentially from 0; wraps to 0 only at new run.
REQ-023 SHALL assert done only in DONE; done SHALL clear the cycle after start is accepted.
REQ-024 SHALL hold key_* outputs stable while key_valid&&!key_ready.

Reset
REQ-025 SHALL, on reset low, asynchronously enter IDLE, empty FIFO, clear counters; in_ready=0, key_valid=0, key_x/y/z=0, key_addr=0, done=0.
REQ-026 SHALL abandon an in-progress run on reset mid-operation; no partial keys emitted after release.

Configuration
REQ-027 SHALL, with CHAOS_KEY_STATS_EN defined, add output nonfinite_cnt (16 bit), saturating count of Inf/NaN components in RUN, cleared on start and reset.
REQ-028 SHALL, without CHAOS_KEY_STATS_EN, omit the port and counter entirely.

Structure
REQ-029 SHALL place FSM state enum, double field positions (EXP_MSB/LSB), NaN key constant in package chaos_pkg.
REQ-030 SHALL instantiate one sub-module, chaos_key_fifo (synchronous FIFO, width 64, depth FIFO_DEPTH, full/empty).

Verification
REQ-031 SHALL test DISCARD=2,SAMPLES=3: start, 5 samples x=6.2554109097 (64'h4019058A7000CFFC) -> 3 keys, first key_x=16'hCFFC^16'h058A=16'hCA76, addr 0,1,2, then done=1.
REQ-032 SHALL test in_y=64'h7FF8000000000000 (NaN) in RUN -> key_y=0; nonfinite_cnt=1 with CHAOS_KEY_STATS_EN.
REQ-033 SHALL test key_ready=0 for 10 cycles -> after FIFO_DEPTH keys, in_ready=0, key_x stable; release -> no loss/duplication.
REQ-034 SHALL test reset low mid-RUN at addr 5 -> all outputs zero immediately; restart emits addr 0.
REQ-035 SHALL test start during RUN -> ignored; start in DONE -> new run, done clears next cycle.
